btn_conditioner: RTL and testbench

//   Input stage between the raw board buttons (btn_right, btn_left, btn_shoot, btn_rst) and the space_invaders game logic.
//   Per button: 2-FF synchroniser, counter-based debouncer, one-cycle press/release pulses, optional auto-repeat pulse train.

---
 rtl/btn_conditioner.sv | 135 +++++++++++++
 tb/tb_btn_conditioner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Button input stage: per-channel 2-FF synchroniser, counter debouncer,
// one-cycle press/release pulses and an optional auto-repeat pulse train.
module btn_conditioner #(
  parameter int                  NUM_BTNS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 1_000_000,
  parameter int                  REPEAT_DELAY    = 30_000_000,
  parameter int                  REPEAT_PERIOD   = 10_000_000,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = 'b0011,
  parameter int                  CNT_W           = $clog2(
    (DEBOUNCE_CYCLES > REPEAT_DELAY)
      ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
      : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD)) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_RPT
  } rpt_state_t;

  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic             sync1, sync2;
    logic             level_q, press_q, release_q;
    logic [CNT_W-1:0] dcnt;
    logic             mismatch, accept;

    assign mismatch = (sync2 != level_q);
    // accept marks the edge on which the debounced level flips
    assign accept   = mismatch && (dcnt == DCNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours (sync1 -> sync2 chain).
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        dcnt      <= '0;
      end else begin
        sync1     <= btn_in[i];
        sync2     <= sync1;
        press_q   <= accept && sync2;
        release_q <= accept && !sync2;
        if (!mismatch || accept) dcnt <= '0;
        else                     dcnt <= dcnt + 1'b1;
        if (accept) level_q <= sync2;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;

    if (REPEAT_MASK[i]) begin : g_rpt
      rpt_state_t       state, state_nxt;
      logic [CNT_W-1:0] rcnt, rcnt_nxt;
      logic             rpt_q, rpt_nxt;

      always_ff @(posedge clk) begin
        if (rst) begin
          state <= IDLE;
          rcnt  <= '0;
          rpt_q <= 1'b0;
        end else begin
          state <= state_nxt;
          rcnt  <= rcnt_nxt;
          rpt_q <= rpt_nxt;
        end
      end

      // NOTE: every output of this block is given a default first, so no
      // path through the case leaves a signal unassigned (no latches).
      always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rpt_nxt   = 1'b0;
        if (accept && !sync2) begin
          // a debounced release wins over any pulse due this cycle
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept && sync2) begin
                state_nxt = HOLD_DELAY;
                rcnt_nxt  = '0;
                rpt_nxt   = 1'b1;
              end
            end
            HOLD_DELAY: begin
              if (rcnt == DLY_LAST) begin
                state_nxt = HOLD_RPT;
                rcnt_nxt  = '0;
                rpt_nxt   = 1'b1;
              end else begin
                rcnt_nxt = rcnt + 1'b1;
              end
            end
            HOLD_RPT: begin
              if (rcnt == PER_LAST) begin
                rcnt_nxt = '0;
                rpt_nxt  = 1'b1;
              end else begin
                rcnt_nxt = rcnt + 1'b1;
              end
            end
            default: begin
              state_nxt = IDLE;
              rcnt_nxt  = '0;
            end
          endcase
        end
      end

      assign btn_repeat[i] = rpt_q;
    end else begin : g_norpt
      assign btn_repeat[i] = press_q;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected output beats,
// a negedge monitor pops and compares whenever any pulse output is active.
module tb_btn_conditioner;

  localparam int NB = 4;

  typedef struct packed {
    int           cyc;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  beat_t mon_b;

  btn_conditioner #(
    .NUM_BTNS       (NB),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (4'b0011)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_beat(input int at, input logic [NB-1:0] lv,
                             input logic [NB-1:0] pr, input logic [NB-1:0] rl,
                             input logic [NB-1:0] rp);
    beat_t b;
    b.cyc = at; b.level = lv; b.press = pr; b.rel = rl; b.rpt = rp;
    exp_q.push_back(b);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   btn_level,   0);
    check({tag, "_press"},   btn_press,   0);
    check({tag, "_release"}, btn_release, 0);
    check({tag, "_repeat"},  btn_repeat,  0);
  endtask

  // Monitor: any active pulse output is one beat to be matched in order.
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_repeat) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {btn_press, btn_release, btn_repeat}, 0);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_cycle",   cyc,         mon_b.cyc);
        check("beat_level",   btn_level,   mon_b.level);
        check("beat_press",   btn_press,   mon_b.press);
        check("beat_release", btn_release, mon_b.rel);
        check("beat_repeat",  btn_repeat,  mon_b.rpt);
      end
    end
  end

  initial begin
    int c, p;
    wait_cyc(3);
    check_all_zero("reset");
    rst = 1'b0;
    wait_cyc(2);

    // 1. Clean press and release on non-repeating channel 2
    c = cyc; btn_in[2] = 1'b1;
    expect_beat(c + 6, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    wait_cyc(20);
    check("t1_level_held", btn_level, 4'b0100);
    c = cyc; btn_in[2] = 1'b0;
    expect_beat(c + 6, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(12);

    // 2. Bounce: 2-cycle pulses/gaps, then held
    btn_in[2] = 1'b1; wait_cyc(2);
    btn_in[2] = 1'b0; wait_cyc(2);
    btn_in[2] = 1'b1; wait_cyc(2);
    btn_in[2] = 1'b0; wait_cyc(2);
    c = cyc; btn_in[2] = 1'b1;
    expect_beat(c + 6, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    wait_cyc(15);
    check("t2_level_held", btn_level, 4'b0100);
    c = cyc; btn_in[2] = 1'b0;
    expect_beat(c + 6, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(12);

    // 3. Glitch of 3 cycles on channel 0: nothing may come out
    btn_in[0] = 1'b1; wait_cyc(3);
    btn_in[0] = 1'b0; wait_cyc(12);
    check("t3_level", btn_level, 4'b0000);

    // 4. Auto-repeat on channel 1, release lands on a pulse-due cycle
    c = cyc; p = c + 6; btn_in[1] = 1'b1;
    expect_beat(p, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    for (int k = 10; k <= 35; k += 5)
      expect_beat(p + k, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(40);
    btn_in[1] = 1'b0;
    expect_beat(p + 40, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    wait_cyc(15);
    check("t4_level", btn_level, 4'b0000);

    // 5. Simultaneous press on channels 0 and 3
    c = cyc; p = c + 6; btn_in = 4'b1001;
    expect_beat(p, 4'b1001, 4'b1001, 4'b0000, 4'b1001);
    for (int k = 10; k <= 20; k += 5)
      expect_beat(p + k, 4'b1001, 4'b0000, 4'b0000, 4'b0001);
    wait_cyc(22);
    btn_in = 4'b0000;
    expect_beat(p + 22, 4'b0000, 4'b0000, 4'b1001, 4'b0000);
    wait_cyc(12);

    // 6. One-cycle reset at P+12 while channel 1 is held
    c = cyc; p = c + 6; btn_in[1] = 1'b1;
    expect_beat(p, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    expect_beat(p + 10, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    wait_cyc(p + 11 - c);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check_all_zero("t6_after_rst");
    expect_beat(p + 18, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    wait_cyc(6);
    btn_in[1] = 1'b0;
    expect_beat(p + 24, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    wait_cyc(15);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
